// File: rtl/multiplicador_seq.sv
// rtl/multiplicador_seq.sv - 8x8 sequential shift-add multiplier, unsigned or signed
// Magnitudes are multiplied unsigned; the sign is applied once at the end through the shared adder.

module somador16x16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_s,
   output logic        o_cout
);

   assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {16'd0, i_cin};

endmodule

module multiplicador_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        modo,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] P,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CALC  = 2'd1;
   localparam logic [1:0] SINAL = 2'd2;
   localparam logic [1:0] FIM   = 2'd3;

   logic [1:0]  r_state;
   logic [15:0] r_mcand;
   logic [7:0]  r_mplier;
   logic [15:0] r_acc;
   logic [2:0]  r_cnt;
   logic        r_neg;
   logic [15:0] r_p;
   logic        r_busy;
   logic        r_done;

   logic [7:0]  w_mag_a;
   logic [7:0]  w_mag_b;
   logic        w_sinal;
   logic [15:0] w_add_a;
   logic [15:0] w_add_b;
   logic [15:0] w_sum;
   logic        w_cout;

   // 0x80 in signed mode yields 0x80, i.e. 128 read as unsigned
   assign w_mag_a = (modo & A[7]) ? (~A + 8'd1) : A;
   assign w_mag_b = (modo & B[7]) ? (~B + 8'd1) : B;

   // One adder: acc+mcand while calculating, ~acc+0+1 for the two's-complement fix-up
   assign w_sinal = (r_state == SINAL);
   assign w_add_a = w_sinal ? ~r_acc : r_acc;
   assign w_add_b = w_sinal ? 16'd0  : r_mcand;

   somador16x16 u_somador (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_sinal),
      .o_s    (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mcand  <= 16'd0;
         r_mplier <= 8'd0;
         r_acc    <= 16'd0;
         r_cnt    <= 3'd0;
         r_neg    <= 1'b0;
         r_p      <= 16'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= {8'd0, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_neg    <= modo & (A[7] ^ B[7]);
                  r_acc    <= 16'd0;
                  r_cnt    <= 3'd0;
                  r_busy   <= 1'b1;
                  r_state  <= CALC;
               end
            end
            CALC: begin
               if (r_mplier[0]) begin
                  r_acc <= w_sum;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  r_state <= SINAL;
               end
            end
            SINAL: begin
               r_p     <= r_neg ? w_sum : r_acc;
               r_done  <= 1'b1;
               r_state <= FIM;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Partial sums never exceed the final magnitude product, so no carry can occur here
   always_ff @(posedge clk) begin
      if (rst_n && r_state == CALC) begin
         assert (!w_cout);
      end
   end

   assign P    = r_p;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_multiplicador_seq.sv
// tb/tb_multiplicador_seq.sv - scoreboard bench for multiplicador_seq

module tb_multiplicador_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        modo;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] P;
   logic        busy;
   logic        done;

   typedef struct {
      logic [15:0] p;
      int          e0;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_done   = 0;
   int          cyc      = 0;
   logic        prev_done = 1'b0;
   logic        prev_rst  = 1'b0;
   logic [15:0] prev_p    = 16'd0;

   multiplicador_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .modo  (modo),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [15:0] model(input logic m, input logic [7:0] a, input logic [7:0] b);
      int x;
      int y;
      int r;
      x = m ? int'($signed(a)) : int'(a);
      y = m ? int'($signed(b)) : int'(b);
      r = x * y;
      return r[15:0];
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            exp_t e;
            n_done++;
            chk("done_expected", int'(q.size() != 0), 1);
            chk("done_width", int'(prev_done), 0);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("P", int'(P), int'(e.p));
               chk("latency", cyc - e.e0, 9);
            end
         end else if (prev_rst) begin
            chk("P_stable", int'(P), int'(prev_p));
         end
      end
      prev_done = done;
      prev_p    = P;
      prev_rst  = rst_n;
   end

   // Called at a negedge; returns at the negedge after E10
   task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b);
      int done_at;
      int busy_n;
      modo  = m;
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q.push_back('{model(m, a, b), cyc});
      modo = ~m;
      A    = 8'($urandom);
      B    = 8'($urandom);
      done_at = -1;
      busy_n  = 0;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         if (busy) busy_n++;
         if (done && done_at < 0) done_at = k;
      end
      chk("done_at", done_at, 9);
      chk("busy_cycles", busy_n, 10);
      chk("idle_after", int'({busy, done}), 0);
   endtask

   initial begin
      int n0;
      int c0;
      rst_n = 1'b0;
      start = 1'b0;
      modo  = 1'b0;
      A     = 8'd0;
      B     = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_P", int'(P), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(1'b0, 8'hFF, 8'hFF);
      run_op(1'b1, 8'hFF, 8'hFF);
      run_op(1'b1, 8'h80, 8'h80);
      run_op(1'b1, 8'h80, 8'h7F);
      run_op(1'b1, 8'h05, 8'hFB);
      run_op(1'b1, 8'h00, 8'h9C);
      run_op(1'b0, 8'h80, 8'h80);
      for (int i = 0; i < 10; i++) begin
         run_op(1'($urandom), 8'($urandom), 8'($urandom));
      end

      // start re-asserted with new operands mid-operation must be ignored
      n0 = n_done;
      modo = 1'b0; A = 8'h03; B = 8'h04; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q.push_back('{model(1'b0, 8'h03, 8'h04), cyc});
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; A = 8'hAA; B = 8'h55; modo = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("busy_prot_dones", n_done - n0, 1);

      // reset in the middle of an operation
      n0 = n_done;
      modo = 1'b0; A = 8'h22; B = 8'h33; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      q.push_back('{model(1'b0, 8'h22, 8'h33), cyc});
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_P", int'(P), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("midrst_no_done", n_done - n0, 0);
      run_op(1'b0, 8'h10, 8'h10);

      // start held high: back-to-back operations every 11 cycles
      n0 = n_done;
      modo = 1'b0; A = 8'h0D; B = 8'h0B; start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int j = 0; j < 3; j++) begin
         q.push_back('{model(1'b0, 8'h0D, 8'h0B), c0 + 11 * j});
      end
      repeat (24) @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("cont_dones", n_done - n0, 3);
      chk("queue_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
